// File: rtl/gtest_objection_ctrl.sv
// rtl/gtest_objection_ctrl.sv - objection counter with drain window and watchdog for end-of-test detection
module gtest_objection_ctrl #(
  parameter int N_SRC       = 4,
  parameter int CNT_W       = 8,
  parameter int DRAIN_CYC   = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [N_SRC-1:0] raise,
  input  logic [N_SRC-1:0] drop,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             done_pulse,
  output logic             timeout,
  output logic             underflow,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wide enough that count + popcount(raise) never wraps.
  localparam int T_W = CNT_W + $clog2(N_SRC + 1) + 1;
  localparam logic [T_W-1:0] CNT_MAX    = {{(T_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [31:0]    DRAIN_LAST = (DRAIN_CYC == 0) ? 32'd0 : 32'(DRAIN_CYC - 1);
  localparam logic [31:0]    WD_LAST    = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
  localparam logic           DRAIN_NONE = (DRAIN_CYC == 0);
  localparam logic           WD_ON      = (TIMEOUT_CYC != 0);

  state_t           state_q;
  logic [31:0]      drain_cnt;
  logic [31:0]      wd_cnt;
  logic [T_W-1:0]   r_sum;
  logic [T_W-1:0]   d_sum;
  logic [T_W-1:0]   t_sum;
  logic [T_W-1:0]   diff;
  logic [CNT_W-1:0] count_nxt;
  logic             uf_nxt;
  logic             ov_nxt;
  logic             cnt_zero;
  logic             drain_hit;
  logic             wd_hit;

  // Next outstanding count: saturate at max, clamp at zero, flag both events.
  always_comb begin
    r_sum     = '0;
    d_sum     = '0;
    diff      = '0;
    count_nxt = count;
    uf_nxt    = 1'b0;
    ov_nxt    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      r_sum = r_sum + T_W'(raise[i]);
      d_sum = d_sum + T_W'(drop[i]);
    end
    t_sum = T_W'(count) + r_sum;
    if (t_sum < d_sum) begin
      count_nxt = '0;
      uf_nxt    = 1'b1;
    end else begin
      diff = t_sum - d_sum;
      if (diff > CNT_MAX) begin
        count_nxt = '1;
        ov_nxt    = 1'b1;
      end else begin
        count_nxt = diff[CNT_W-1:0];
      end
    end
  end

  assign cnt_zero  = (count_nxt == '0);
  assign drain_hit = cnt_zero && (drain_cnt == DRAIN_LAST);
  assign wd_hit    = WD_ON && (wd_cnt == WD_LAST);

  // Count register, sticky flags and the completion FSM; clear overrides all else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count      <= '0;
      drain_cnt  <= '0;
      wd_cnt     <= '0;
      done_pulse <= 1'b0;
      timeout    <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      count      <= '0;
      drain_cnt  <= '0;
      wd_cnt     <= '0;
      done_pulse <= 1'b0;
      timeout    <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count      <= count_nxt;
      done_pulse <= 1'b0;
      if (uf_nxt) underflow <= 1'b1;
      if (ov_nxt) overflow  <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            wd_cnt    <= '0;
            drain_cnt <= '0;
            if (!cnt_zero) begin
              state_q <= ACTIVE;
            end else if (DRAIN_NONE) begin
              state_q    <= DONE;
              done_pulse <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        ACTIVE: begin
          wd_cnt    <= wd_cnt + 32'd1;
          drain_cnt <= '0;
          if (cnt_zero && DRAIN_NONE) begin
            state_q    <= DONE;
            done_pulse <= 1'b1;
          end else if (wd_hit) begin
            state_q    <= DONE;
            done_pulse <= 1'b1;
            timeout    <= 1'b1;
          end else if (cnt_zero) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (drain_hit) begin
            state_q    <= DONE;
            done_pulse <= 1'b1;
          end else if (wd_hit) begin
            state_q    <= DONE;
            done_pulse <= 1'b1;
            timeout    <= 1'b1;
          end else if (!cnt_zero) begin
            state_q   <= ACTIVE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        default: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q == ACTIVE) || (state_q == DRAIN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_gtest_objection_ctrl.sv
// tb/tb_gtest_objection_ctrl.sv - scoreboard-driven directed bench for gtest_objection_ctrl
module tb_gtest_objection_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_ACT = 2'd1, S_DRN = 2'd2, S_DONE = 2'd3;
  // flag vector order: busy, done, done_pulse, timeout, underflow, overflow
  localparam logic [5:0] F_BUSY = 6'b100000, F_DONE = 6'b010000, F_DP = 6'b001000;
  localparam logic [5:0] F_TO = 6'b000100, F_UF = 6'b000010, F_OF = 6'b000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st0 = 1'b0, cl0 = 1'b0, st1 = 1'b0, cl1 = 1'b0;
  logic [3:0] r0 = '0, d0 = '0, r1 = '0, d1 = '0;
  logic [7:0] count0;
  logic [1:0] count1;
  logic [1:0] state0, state1;
  logic       busy0, done0, dp0, to0, uf0, of0;
  logic       busy1, done1, dp1, to1, uf1, of1;

  int n_assert = 0;
  int n_fail   = 0;
  logic sel = 1'b0;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic [1:0] st;
    logic [5:0] fl;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  gtest_objection_ctrl #(.N_SRC(4), .CNT_W(8), .DRAIN_CYC(16), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .clear(cl0), .raise(r0), .drop(d0),
    .count(count0), .state(state0), .busy(busy0), .done(done0), .done_pulse(dp0),
    .timeout(to0), .underflow(uf0), .overflow(of0)
  );

  gtest_objection_ctrl #(.N_SRC(4), .CNT_W(2), .DRAIN_CYC(16), .TIMEOUT_CYC(100)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .clear(cl1), .raise(r1), .drop(d1),
    .count(count1), .state(state1), .busy(busy1), .done(done1), .done_pulse(dp1),
    .timeout(to1), .underflow(uf1), .overflow(of1)
  );

  task automatic push_exp(input string tag, input logic [7:0] c, input logic [1:0] s, input logic [5:0] f);
    exp_t e;
    e.tag = tag; e.cnt = c; e.st = s; e.fl = f;
    sbq.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [7:0] oc;
    logic [1:0] os;
    logic [5:0] ofl;
    e = sbq.pop_front();
    if (sel) begin
      oc = {6'd0, count1}; os = state1; ofl = {busy1, done1, dp1, to1, uf1, of1};
    end else begin
      oc = count0; os = state0; ofl = {busy0, done0, dp0, to0, uf0, of0};
    end
    n_assert++;
    assert (oc === e.cnt) else begin
      n_fail++;
      $error("FAIL %s count: got %0d expected %0d", e.tag, oc, e.cnt);
    end
    n_assert++;
    assert (os === e.st) else begin
      n_fail++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, os, e.st);
    end
    n_assert++;
    assert (ofl === e.fl) else begin
      n_fail++;
      $error("FAIL %s flags: got %b expected %b", e.tag, ofl, e.fl);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic s, input logic c,
                     input string tag, input logic [7:0] ec, input logic [1:0] es, input logic [5:0] ef);
    if (sel) begin r1 = r; d1 = d; st1 = s; cl1 = c; end
    else begin r0 = r; d0 = d; st0 = s; cl0 = c; end
    push_exp(tag, ec, es, ef);
    @(posedge clk);
    #1;
    r0 = '0; d0 = '0; st0 = 1'b0; cl0 = 1'b0;
    r1 = '0; d1 = '0; st1 = 1'b0; cl1 = 1'b0;
    chk();
  endtask

  // Idle cycles remaining in DRAIN, followed by the DONE edge and one settled DONE cycle.
  task automatic drain_to_done(input string tag, input int idle_cycles, input logic [5:0] extra);
    for (int k = 0; k < idle_cycles; k++) cyc(4'h0, 4'h0, 1'b0, 1'b0, tag, 8'd0, S_DRN, F_BUSY | extra);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, {tag, "_done"}, 8'd0, S_DONE, F_DONE | F_DP | extra);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, {tag, "_hold"}, 8'd0, S_DONE, F_DONE | extra);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; push_exp("reset0", 8'd0, S_IDLE, 6'd0); chk();
    sel = 1'b1; push_exp("reset1", 8'd0, S_IDLE, 6'd0); chk();
    sel = 1'b0;
    rst = 1'b0;

    // 1: start with nothing outstanding -> DRAIN, done 16 edges after start
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t1_start", 8'd0, S_DRN, F_BUSY);
    drain_to_done("t1", 15, 6'd0);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t1_start_in_done", 8'd0, S_DONE, F_DONE);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, "t1_clear", 8'd0, S_IDLE, 6'd0);

    // 2: raises before start, partial drops keep ACTIVE, last drop enters DRAIN
    cyc(4'b0111, 4'h0, 1'b0, 1'b0, "t2_raise", 8'd3, S_IDLE, 6'd0);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t2_start", 8'd3, S_ACT, F_BUSY);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t2_start_ignored", 8'd3, S_ACT, F_BUSY);
    cyc(4'h0, 4'b0011, 1'b0, 1'b0, "t2_drop2", 8'd1, S_ACT, F_BUSY);
    cyc(4'h0, 4'b0100, 1'b0, 1'b0, "t2_drop1", 8'd0, S_DRN, F_BUSY);
    drain_to_done("t2", 15, 6'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, "t2_clear", 8'd0, S_IDLE, 6'd0);

    // 3: raise at drain count 10 returns to ACTIVE; drop restarts a full drain
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t3_start", 8'd0, S_DRN, F_BUSY);
    for (int k = 0; k < 10; k++) cyc(4'h0, 4'h0, 1'b0, 1'b0, "t3_drain", 8'd0, S_DRN, F_BUSY);
    cyc(4'b0001, 4'h0, 1'b0, 1'b0, "t3_reraise", 8'd1, S_ACT, F_BUSY);
    cyc(4'h0, 4'b0001, 1'b0, 1'b0, "t3_redrop", 8'd0, S_DRN, F_BUSY);
    drain_to_done("t3", 15, 6'd0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, "t3_clear", 8'd0, S_IDLE, 6'd0);

    // 4: underflow clamps and sticks; simultaneous raise/drop of one source nets zero
    cyc(4'b0001, 4'h0, 1'b0, 1'b0, "t4_raise", 8'd1, S_IDLE, 6'd0);
    cyc(4'h0, 4'b1111, 1'b0, 1'b0, "t4_underflow", 8'd0, S_IDLE, F_UF);
    cyc(4'b0001, 4'h0, 1'b0, 1'b0, "t4_raise2", 8'd1, S_IDLE, F_UF);
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, "t4_net0", 8'd1, S_IDLE, F_UF);
    cyc(4'b0010, 4'h0, 1'b1, 1'b1, "t4_clear_beats_start", 8'd0, S_IDLE, 6'd0);

    // 6: async reset mid-DRAIN takes effect without a clock edge
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t6_start", 8'd0, S_DRN, F_BUSY);
    for (int k = 0; k < 3; k++) cyc(4'h0, 4'h0, 1'b0, 1'b0, "t6_drain", 8'd0, S_DRN, F_BUSY);
    #2;
    rst = 1'b1;
    #1;
    push_exp("t6_async_rst", 8'd0, S_IDLE, 6'd0); chk();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t6_restart", 8'd0, S_DRN, F_BUSY);
    drain_to_done("t6", 15, 6'd0);

    // 5: CNT_W=2 saturation, then watchdog forces DONE 100 edges after start
    sel = 1'b1;
    cyc(4'b1111, 4'h0, 1'b0, 1'b0, "t5_overflow", 8'd3, S_IDLE, F_OF);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, "t5_start", 8'd3, S_ACT, F_BUSY | F_OF);
    for (int k = 0; k < 99; k++) cyc(4'h0, 4'h0, 1'b0, 1'b0, "t5_hold", 8'd3, S_ACT, F_BUSY | F_OF);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, "t5_timeout", 8'd3, S_DONE, F_DONE | F_DP | F_TO | F_OF);
    cyc(4'h0, 4'b0001, 1'b0, 1'b0, "t5_drop_in_done", 8'd2, S_DONE, F_DONE | F_TO | F_OF);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, "t5_clear", 8'd0, S_IDLE, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
